// File: rtl/rs232_pkg.sv
// Shared RS232 definitions so the transmitter and receiver agree on framing and baud timing.
// Holds the receiver state encoding, data width and default clocks-per-bit.
package rs232_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; latency 2 cycles, no backpressure.
// The reset value is a parameter so idle-high lines do not glitch active out of reset.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_rx.sv
// 8N1 serial receiver: mid-bit sampling of a synchronized RX line, one-cycle DONE/FRAME_ERR strobes.
// DONE appears HALF_BIT + 9*CLKS_PER_BIT + ~3 cycles after the start edge; there is no backpressure.
module serial_rx
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 DONE,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int IW       = $clog2(DATA_BITS);

  logic                 w_rx_s;
  rx_state_e            r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_frame_err;
  logic                 r_busy;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (RX),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (r_cnt == CW'(HALF_BIT - 1)) begin
            r_cnt <= '0;
            // Line back high at mid-start-bit means it was noise, not a frame.
            if (!w_rx_s) begin
              r_state <= ST_DATA;
              r_idx   <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_idx == IW'(DATA_BITS - 1)) begin
              r_state <= ST_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DATA      = r_data;
  assign DONE      = r_done;
  assign FRAME_ERR = r_frame_err;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_serial_rx.sv
// Directed-frame bench for serial_rx with a scoreboard queue of expected DONE/FRAME_ERR events.
module tb_serial_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = HALF + 9 * CPB + 3;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       done;
  logic       frame_err;
  logic       busy;

  int   checks;
  int   failures;
  int   cyc;
  exp_t exp_q[$];

  serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX        (rx),
    .DATA      (data),
    .DONE      (done),
    .FRAME_ERR (frame_err),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected_range=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (done === 1'b1 && frame_err === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_and_ferr_together actual=11 expected=not_both");
    end else if (done === 1'b1 || frame_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=done%0b_ferr%0b expected=none", done, frame_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_kind_ferr", int'(frame_err), int'(e.err));
        check("data", int'(data), int'(e.data));
        check_range("latency", cyc - e.t0, LAT - 1, LAT + 1);
      end
    end
  end

  task automatic bit_period(input logic v);
    rx = v;
    repeat (CPB) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit exp_err,
                            input logic [7:0] exp_data);
    exp_t e;
    logic [7:0] bb;
    bb       = b;
    e.err    = exp_err;
    e.data   = exp_data;
    e.t0     = cyc;
    exp_q.push_back(e);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(bb[i]);
    bit_period(stop_v);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int busy_cnt;
    int waited;
    logic [7:0] abort_b;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rx       = 1'b1;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", int'(data), 8'h00);
    check("reset_done", int'(done), 0);
    check("reset_ferr", int'(frame_err), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    idle(2 * CPB);

    // Directed frames and loopback patterns.
    send_frame(8'hD2, 1'b1, 1'b0, 8'hD2);
    idle(CPB);
    send_frame(8'h00, 1'b1, 1'b0, 8'h00);
    idle(CPB);
    send_frame(8'hFF, 1'b1, 1'b0, 8'hFF);
    idle(CPB);
    send_frame(8'h55, 1'b1, 1'b0, 8'h55);
    idle(2 * CPB);

    // Glitch shorter than half a bit.
    rx = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
    end
    check_range("glitch_busy_cycles", busy_cnt, 1, HALF + 3);
    check("glitch_busy_end", int'(busy), 0);
    check("glitch_data_kept", int'(data), 8'h55);
    @(posedge clk);
    #1;

    // Framing error followed by a held break, then a clean frame.
    send_frame(8'hA5, 1'b0, 1'b1, 8'h55);
    rx = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    check("break_busy", int'(busy), 1);
    idle(2 * CPB);
    send_frame(8'h3C, 1'b1, 1'b0, 8'h3C);
    idle(2 * CPB);

    // Back-to-back frames, no idle between stop and start.
    send_frame(8'h01, 1'b1, 1'b0, 8'h01);
    send_frame(8'h80, 1'b1, 1'b0, 8'h80);
    idle(2 * CPB);

    // Reset during bit 4 aborts the frame.
    abort_b = 8'h10;
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(abort_b[i]);
    rx = abort_b[4];
    repeat (HALF) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_data", int'(data), 8'h00);
    check("midreset_done", int'(done), 0);
    check("midreset_ferr", int'(frame_err), 0);
    check("midreset_busy", int'(busy), 0);
    rst = 1'b0;
    idle(2 * CPB);
    send_frame(8'h7E, 1'b1, 1'b0, 8'h7E);
    idle(3 * CPB);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20 * CPB) begin
      @(posedge clk);
      waited++;
    end
    check("drain_pending_events", exp_q.size(), 0);
    check("final_data", int'(data), 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
